dkong3_layer_mixer: RTL and testbench

DKONG3_LAYER_MIXER -- requirements
Module: dkong3_layer_mixer

---
 rtl/dkong3_layer_mixer.sv | 146 ++++++++++++++
 tb/tb_dkong3_layer_mixer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/dkong3_layer_mixer.sv
// Priority layer mixer: picks the highest-priority opaque layer, looks its colour up in a
// banked palette RAM (3 pixel-strobe pipeline) and counts per-frame layer collisions.
module dkong3_layer_mixer #(
    parameter int NLAYERS = 2,
    parameter int COLW    = 4,
    parameter int PIXW    = 2,
    parameter int BANKW   = 2,
    parameter int OUTW    = 4,
    parameter int CNTW    = 16
) (
    input  logic                             I_CLK_24M,
    input  logic                             I_RESET,
    input  logic                             I_PIX_CE,
    input  logic [NLAYERS*(COLW+PIXW)-1:0]   I_LAYER_D,
    input  logic [NLAYERS-1:0]               I_LAYER_EN,
    input  logic                             I_CMPBLKn,
    input  logic                             I_VBLK,
    input  logic [BANKW-1:0]                 I_CPAL_SEL,
    input  logic                             I_PAL_WE,
    input  logic [BANKW+COLW+PIXW-1:0]       I_PAL_A,
    input  logic [3*OUTW-1:0]                I_PAL_D,
    output logic [OUTW-1:0]                  O_R,
    output logic [OUTW-1:0]                  O_G,
    output logic [OUTW-1:0]                  O_B,
    output logic [2:0]                       O_WIN_LAYER,
    output logic [CNTW-1:0]                  O_COLL_CNT
);

    localparam int LW    = COLW + PIXW;
    localparam int AW    = BANKW + LW;
    localparam int DEPTH = 1 << AW;
    localparam int RGBW  = 3 * OUTW;
    localparam logic [2:0] NO_WIN = 3'd7;

    if (NLAYERS < 2 || NLAYERS > 4) begin : g_bad_nlayers
        $error("dkong3_layer_mixer: NLAYERS must be in 2..4");
    end
    if (COLW < 1 || PIXW < 1 || BANKW < 1 || OUTW < 1 || CNTW < 1) begin : g_bad_width
        $error("dkong3_layer_mixer: COLW, PIXW, BANKW, OUTW and CNTW must be at least 1");
    end

    logic [NLAYERS-1:0] opaque;
    logic [2:0]         n_opaque;
    logic [2:0]         win_idx;
    logic [LW-1:0]      win_sel;
    logic               found;
    logic               collision;

    logic [BANKW-1:0]   bank;
    logic               blk_n_prev;
    logic               vblk_prev;
    logic               vblk_rise;
    logic [CNTW-1:0]    coll_cnt;

    logic [AW-1:0]      s1_idx;
    logic [2:0]         s1_win;
    logic               s1_blk_n;
    logic [RGBW-1:0]    s2_rgb;
    logic [2:0]         s2_win;
    logic               s2_blk_n;

    logic [RGBW-1:0]    pal [DEPTH];

    // Lowest index wins; a transparent or disabled layer never wins.
    always_comb begin
        opaque   = '0;
        n_opaque = '0;
        win_idx  = NO_WIN;
        win_sel  = '0;
        found    = 1'b0;
        for (int unsigned i = 0; i < NLAYERS; i++) begin
            opaque[i] = I_LAYER_EN[i] && (I_LAYER_D[i*LW +: PIXW] != '0);
            if (opaque[i]) begin
                n_opaque = n_opaque + 3'd1;
                if (!found) begin
                    found   = 1'b1;
                    win_idx = 3'(i);
                    win_sel = I_LAYER_D[i*LW +: LW];
                end
            end
        end
    end

    assign collision = I_CMPBLKn && (n_opaque >= 3'd2);
    assign vblk_rise = I_VBLK && !vblk_prev;

    always_ff @(posedge I_CLK_24M) begin
        if (I_RESET) begin
            bank        <= '0;
            blk_n_prev  <= 1'b0;
            vblk_prev   <= 1'b1;
            coll_cnt    <= '0;
            O_COLL_CNT  <= '0;
            s1_idx      <= '0;
            s1_win      <= NO_WIN;
            s1_blk_n    <= 1'b0;
            s2_win      <= NO_WIN;
            s2_blk_n    <= 1'b0;
            O_R         <= '0;
            O_G         <= '0;
            O_B         <= '0;
            O_WIN_LAYER <= NO_WIN;
        end else begin
            vblk_prev <= I_VBLK;
            // A collision coinciding with the frame boundary is dropped, not carried over.
            if (vblk_rise) begin
                O_COLL_CNT <= coll_cnt;
                coll_cnt   <= '0;
            end else if (I_PIX_CE && collision && coll_cnt != '1) begin
                coll_cnt <= coll_cnt + 1'b1;
            end

            if (I_PIX_CE) begin
                blk_n_prev <= I_CMPBLKn;
                if (blk_n_prev && !I_CMPBLKn)
                    bank <= I_CPAL_SEL;

                s1_idx   <= {bank, win_sel};
                s1_win   <= win_idx;
                s1_blk_n <= I_CMPBLKn;

                s2_win   <= s1_win;
                s2_blk_n <= s1_blk_n;

                if (s2_blk_n) begin
                    {O_R, O_G, O_B} <= s2_rgb;
                    O_WIN_LAYER     <= s2_win;
                end else begin
                    O_R         <= '0;
                    O_G         <= '0;
                    O_B         <= '0;
                    O_WIN_LAYER <= NO_WIN;
                end
            end
        end
    end

    // Palette RAM: read-before-write on an address clash; contents survive reset.
    always_ff @(posedge I_CLK_24M) begin
        if (I_PAL_WE && !I_RESET)
            pal[I_PAL_A] <= I_PAL_D;
        if (I_PIX_CE)
            s2_rgb <= pal[s1_idx];
    end

endmodule

// File: tb/tb_dkong3_layer_mixer.sv
// Scoreboard bench for dkong3_layer_mixer: directed pixels push expected outputs, a monitor
// pops one per pixel strobe once the 3-strobe pipeline has filled.
module tb_dkong3_layer_mixer;

    localparam logic [5:0] L31 = 6'h0D;  // {col 3, pix 1}
    localparam logic [5:0] L52 = 6'h16;  // {col 5, pix 2}
    localparam logic [5:0] L71 = 6'h1D;  // {col 7, pix 1}
    localparam logic [5:0] L30 = 6'h0C;  // {col 3, pix 0}
    localparam logic [5:0] L50 = 6'h14;  // {col 5, pix 0}

    logic        clk;
    logic        rst;
    logic        ce;
    logic [11:0] layer_d;
    logic [1:0]  layer_en;
    logic        blk_n;
    logic        vblk;
    logic [1:0]  cpal_sel;
    logic        pal_we;
    logic [7:0]  pal_a;
    logic [11:0] pal_d;
    logic [3:0]  r, g, b;
    logic [2:0]  win;
    logic [3:0]  coll_cnt;
    logic [14:0] dout;

    logic [14:0] q[$];
    logic [14:0] last_exp;
    int          checks;
    int          errors;
    int          strobes;

    dkong3_layer_mixer #(.NLAYERS(2), .COLW(4), .PIXW(2), .BANKW(2), .OUTW(4), .CNTW(4)) dut (
        .I_CLK_24M  (clk),
        .I_RESET    (rst),
        .I_PIX_CE   (ce),
        .I_LAYER_D  (layer_d),
        .I_LAYER_EN (layer_en),
        .I_CMPBLKn  (blk_n),
        .I_VBLK     (vblk),
        .I_CPAL_SEL (cpal_sel),
        .I_PAL_WE   (pal_we),
        .I_PAL_A    (pal_a),
        .I_PAL_D    (pal_d),
        .O_R        (r),
        .O_G        (g),
        .O_B        (b),
        .O_WIN_LAYER(win),
        .O_COLL_CNT (coll_cnt)
    );

    assign dout = {r, g, b, win};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: output after strobe n (n >= 3 since reset) belongs to the pixel sampled at n-2.
    initial begin
        strobes  = 0;
        last_exp = {12'h000, 3'd7};
        forever begin
            @(posedge clk);
            if (rst) begin
                strobes = 0;
            end else if (ce) begin
                strobes++;
                #2;
                if (strobes < 3) begin
                    check("post_reset_blank", 32'(dout), 32'({12'h000, 3'd7}));
                    last_exp = {12'h000, 3'd7};
                end else if (q.size() == 0) begin
                    check("scoreboard_underflow", 32'(q.size()), 32'd1);
                end else begin
                    last_exp = q.pop_front();
                    check("pixel", 32'(dout), 32'(last_exp));
                end
            end
        end
    end

    task automatic pix(input logic [5:0] l0, input logic [5:0] l1, input logic [1:0] en,
                       input logic bn, input logic [11:0] rgb, input logic [2:0] w);
        layer_d  = {l1, l0};
        layer_en = en;
        blk_n    = bn;
        ce       = 1'b1;
        q.push_back({rgb, w});
        @(posedge clk);
        #1;
        ce     = 1'b0;
        pal_we = 1'b0;
    endtask

    task automatic pal_wr(input logic [7:0] a, input logic [11:0] d);
        pal_we = 1'b1;
        pal_a  = a;
        pal_d  = d;
        @(posedge clk);
        #1;
        pal_we = 1'b0;
    endtask

    task automatic vblk_pulse();
        vblk = 1'b1;
        @(posedge clk);
        #1;
        vblk = 1'b0;
    endtask

    task automatic idle();
        ce = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        ce       = 1'b0;
        layer_d  = '0;
        layer_en = '0;
        blk_n    = 1'b0;
        vblk     = 1'b0;
        cpal_sel = 2'd0;
        pal_we   = 1'b0;
        pal_a    = '0;
        pal_d    = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_out", 32'(dout), 32'({12'h000, 3'd7}));
        check("reset_cnt", 32'(coll_cnt), 32'd0);
        rst = 1'b0;

        pal_wr(8'h0D, 12'hF80);  // {0,3,1}
        pal_wr(8'h16, 12'h0AF);  // {0,5,2}
        pal_wr(8'h80, 12'h123);  // {2,0,0}
        pal_wr(8'h4D, 12'h4C2);  // {1,3,1}
        pal_wr(8'h1D, 12'h111);  // {0,7,1}
        pal_wr(8'h00, 12'h9D6);  // {0,0,0}
        // write attempted under reset must be ignored
        rst = 1'b1;
        q.delete();
        pal_wr(8'h1D, 12'hEEE);
        rst = 1'b0;

        // line 1, bank 0
        pix(6'h00, 6'h00, 2'b00, 1'b0, 12'h000, 3'd7);
        pix(L31, L52, 2'b11, 1'b1, 12'hF80, 3'd0);
        pix(L31, L52, 2'b10, 1'b1, 12'h0AF, 3'd1);
        pix(L30, L50, 2'b11, 1'b1, 12'h9D6, 3'd7);
        pix(L71, L52, 2'b01, 1'b1, 12'h111, 3'd0);
        cpal_sel = 2'd1;
        pix(L31, L52, 2'b01, 1'b1, 12'hF80, 3'd0);
        // overwrite {0,3,1} on the strobe that reads it for the previous pixel
        pal_we = 1'b1; pal_a = 8'h0D; pal_d = 12'h555;
        pix(L52, L31, 2'b01, 1'b1, 12'h0AF, 3'd0);
        pix(L31, L52, 2'b01, 1'b1, 12'h555, 3'd0);

        layer_d  = 12'hFFF;
        layer_en = 2'b11;
        blk_n    = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("hold", 32'(dout), 32'(last_exp));
        end
        pix(L52, 6'h00, 2'b01, 1'b1, 12'h0AF, 3'd0);
        pix(L31, L52, 2'b11, 1'b0, 12'h000, 3'd7);  // falling blank: bank -> 1

        // line 2, bank 1
        pix(6'h00, 6'h00, 2'b00, 1'b0, 12'h000, 3'd7);
        pix(L31, 6'h00, 2'b01, 1'b1, 12'h4C2, 3'd0);
        pix(L31, L31, 2'b11, 1'b1, 12'h4C2, 3'd0);
        cpal_sel = 2'd2;
        pix(6'h00, 6'h00, 2'b00, 1'b0, 12'h000, 3'd7);

        // line 3, bank 2
        pix(L30, L50, 2'b11, 1'b1, 12'h123, 3'd7);
        pix(L31, L52, 2'b00, 1'b1, 12'h123, 3'd7);
        cpal_sel = 2'd0;
        pix(L31, L52, 2'b11, 1'b0, 12'h000, 3'd7);

        // frame end with a collision on the same cycle: that one is lost
        vblk = 1'b1;
        pix(L31, L52, 2'b11, 1'b1, 12'h555, 3'd0);
        check("coll_frame1", 32'(coll_cnt), 32'd2);
        pix(L31, L52, 2'b11, 1'b1, 12'h555, 3'd0);
        vblk = 1'b0;
        pix(6'h00, 6'h00, 2'b00, 1'b0, 12'h000, 3'd7);
        vblk_pulse();
        check("coll_lost", 32'(coll_cnt), 32'd1);

        for (int i = 0; i < 20; i++)
            pix(L31, L52, 2'b11, 1'b1, 12'h555, 3'd0);
        vblk_pulse();
        check("coll_sat", 32'(coll_cnt), 32'd15);
        idle();
        vblk_pulse();
        check("coll_cleared", 32'(coll_cnt), 32'd0);

        // reset with pixels in flight
        pix(L31, L52, 2'b01, 1'b1, 12'h555, 3'd0);
        pix(L52, 6'h00, 2'b01, 1'b1, 12'h0AF, 3'd0);
        idle();
        rst = 1'b1;
        q.delete();
        idle();
        check("rst_mid_out", 32'(dout), 32'({12'h000, 3'd7}));
        check("rst_mid_cnt", 32'(coll_cnt), 32'd0);
        rst = 1'b0;
        pix(L71, 6'h00, 2'b01, 1'b1, 12'h111, 3'd0);
        pix(L52, 6'h00, 2'b01, 1'b1, 12'h0AF, 3'd0);
        pix(6'h00, 6'h00, 2'b00, 1'b0, 12'h000, 3'd7);
        pix(6'h00, 6'h00, 2'b00, 1'b0, 12'h000, 3'd7);
        idle();
        check("sb_drain", 32'(q.size()), 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
